// File: rtl/cnn_seq_pkg.sv
// Shared types and size helpers for the CNN stimulus sequencer.
// Geometry is derived from the image side and pooling stride.
package cnn_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN
   } state_t;

   function automatic int image_size(input int iw, input int pn);
      int side;
      side = iw / (pn * pn);
      return side * side;
   endfunction

   function automatic int num_pix(input int iw);
      return iw * iw;
   endfunction

   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_up_counter.sv
// Up counter with synchronous clear; saturates at all-ones
// instead of wrapping.
module seq_up_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/cnn_stimulus_sequencer.sv
// Feeds weight rows then pixels into the CNN core and counts
// its result beats until the core signals completion.
module cnn_stimulus_sequencer
   import cnn_seq_pkg::*;
#(
   parameter int BitSize      = 4,
   parameter int ImageWidth   = 8,
   parameter int PoolingN     = 2,
   parameter int MaxNumNerves = 3,
   parameter int M_W_BitSize  = 4,
   parameter int L1Nerves     = 2,
   parameter int L0Nerves     = 3,
   localparam int NumRows = image_size(ImageWidth, PoolingN) + L1Nerves,
   localparam int NumPix  = num_pix(ImageWidth),
   localparam int RW      = MaxNumNerves * M_W_BitSize,
   localparam int WAW     = addr_w(NumRows),
   localparam int PAW     = addr_w(NumPix)
) (
   input  logic                      clk,
   input  logic                      res_n,
   input  logic                      start,
   output logic [WAW-1:0]            w_addr,
   input  logic [RW-1:0]             w_rdata,
   output logic [PAW-1:0]            pix_addr,
   input  logic [BitSize-1:0]        pix_rdata,
   output logic [RW-1:0]             in_weights,
   output logic                      w_valid,
   output logic                      in_valid,
   output logic [BitSize-1:0]        in_data,
   input  logic                      dut_ready,
   input  logic                      res_valid,
   input  logic [L0Nerves*BitSize-1:0] res_data,
   input  logic                      res_done,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               beat_count
);

   localparam int WCW = addr_w(NumRows + 1);
   localparam int PCW = addr_w(NumPix + 1);

   state_t               state_q, state_d;
   logic [RW-1:0]        wts_q, wts_d;
   logic                 wv_q, wv_d;
   logic                 iv_q, iv_d;
   logic [BitSize-1:0]   dat_q, dat_d;
   logic                 done_q, done_d;
   logic                 rdone_q, rdone_d;

   logic [WCW-1:0]       w_idx_q;
   logic [PCW-1:0]       pix_idx_q;
   logic                 w_clr, w_inc;
   logic                 p_clr, p_inc;
   logic                 b_clr, b_inc;
   logic                 rows_done, pix_done;
   logic                 unused_res;

   seq_up_counter #(.WIDTH(WCW)) u_w_idx (
      .clk     (clk),
      .res_n   (res_n),
      .clr_i   (w_clr),
      .inc_i   (w_inc),
      .count_o (w_idx_q)
   );

   // Points at the next pixel to fetch, one ahead of in_data.
   seq_up_counter #(.WIDTH(PCW)) u_pix_idx (
      .clk     (clk),
      .res_n   (res_n),
      .clr_i   (p_clr),
      .inc_i   (p_inc),
      .count_o (pix_idx_q)
   );

   seq_up_counter #(.WIDTH(16)) u_beats (
      .clk     (clk),
      .res_n   (res_n),
      .clr_i   (b_clr),
      .inc_i   (b_inc),
      .count_o (beat_count)
   );

   assign rows_done = (w_idx_q == WCW'(NumRows));
   assign pix_done  = (pix_idx_q == PCW'(NumPix));
   assign busy      = (state_q != IDLE);
   assign b_clr     = start && (state_q == IDLE);
   assign b_inc     = res_valid && busy;

   always_comb begin
      state_d = state_q;
      wts_d   = wts_q;
      wv_d    = 1'b0;
      iv_d    = iv_q;
      dat_d   = dat_q;
      done_d  = 1'b0;
      rdone_d = rdone_q | (res_done && busy);
      w_clr   = 1'b0;
      w_inc   = 1'b0;
      p_clr   = 1'b0;
      p_inc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_W;
               w_clr   = 1'b1;
               p_clr   = 1'b1;
               rdone_d = 1'b0;
            end
         end
         LOAD_W: begin
            if (!rows_done) begin
               wts_d = w_rdata;
               wv_d  = 1'b1;
               w_inc = 1'b1;
            end else begin
               state_d = STREAM;
               iv_d    = 1'b1;
               dat_d   = pix_rdata;
               p_inc   = 1'b1;
            end
         end
         STREAM: begin
            if (dut_ready) begin
               if (pix_done) begin
                  iv_d  = 1'b0;
                  dat_d = '0;
                  // An early res_done lets the run end right away.
                  if (rdone_q || res_done) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = DRAIN;
                  end
               end else begin
                  dat_d = pix_rdata;
                  p_inc = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (res_done || rdone_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= IDLE;
         wts_q   <= '0;
         wv_q    <= 1'b0;
         iv_q    <= 1'b0;
         dat_q   <= '0;
         done_q  <= 1'b0;
         rdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wts_q   <= wts_d;
         wv_q    <= wv_d;
         iv_q    <= iv_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
         rdone_q <= rdone_d;
      end
   end

   assign w_addr     = w_idx_q[WAW-1:0];
   assign pix_addr   = pix_idx_q[PAW-1:0];
   assign in_weights = wts_q;
   assign w_valid    = wv_q;
   assign in_valid   = iv_q;
   assign in_data    = dat_q;
   assign done       = done_q;
   assign unused_res = ^res_data;

endmodule

// File: tb/tb_cnn_stimulus_sequencer.sv
// Directed scoreboard bench for cnn_stimulus_sequencer.
module tb_cnn_stimulus_sequencer;

   logic        clk = 1'b0;
   logic        res_n;
   logic        start;
   logic [2:0]  w_addr;
   logic [11:0] w_rdata;
   logic [5:0]  pix_addr;
   logic [3:0]  pix_rdata;
   logic [11:0] in_weights;
   logic        w_valid;
   logic        in_valid;
   logic [3:0]  in_data;
   logic        dut_ready;
   logic        res_valid;
   logic [11:0] res_data;
   logic        res_done;
   logic        busy;
   logic        done;
   logic [15:0] beat_count;

   logic [11:0] wmem [0:7];
   logic [3:0]  pmem [0:63];
   logic [11:0] wq [$];
   logic [3:0]  pq [$];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign w_rdata   = wmem[w_addr];
   assign pix_rdata = pmem[pix_addr];

   cnn_stimulus_sequencer dut (
      .clk        (clk),
      .res_n      (res_n),
      .start      (start),
      .w_addr     (w_addr),
      .w_rdata    (w_rdata),
      .pix_addr   (pix_addr),
      .pix_rdata  (pix_rdata),
      .in_weights (in_weights),
      .w_valid    (w_valid),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .dut_ready  (dut_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_done   (res_done),
      .busy       (busy),
      .done       (done),
      .beat_count (beat_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 1 = ready pattern 1,0,0,1; rd_early = accepted count at
   // which res_done is pulsed early (-1: after drain); rst_at =
   // accepted count at which reset is applied (-1: none).
   task automatic run(input int mode, input int rd_early,
                      input int rst_at, input bit repulse,
                      input bit beats);
      int k, acc, sc, exp_done_k, last_k, nb, last_b;
      bit seen_w, seen_in, rd_sent, fin, sp2;
      logic [11:0] ew;
      logic [3:0]  ep;
      wq.delete();
      pq.delete();
      for (int i = 0; i < 6; i++) wq.push_back(wmem[i]);
      for (int i = 0; i < 64; i++) pq.push_back(pmem[i]);
      k = -1; acc = 0; sc = 0; exp_done_k = -1; last_k = -1;
      nb = 0; last_b = -1;
      seen_w = 0; seen_in = 0; rd_sent = 0; fin = 0; sp2 = 0;
      start = 1'b1;
      while (!fin && k < 1000) begin
         @(posedge clk);
         #1;
         k++;
         start = 1'b0;
         res_done = 1'b0;
         res_valid = 1'b0;
         res_data = '0;
         if (k == 0) begin
            chk("busy_up", 32'(busy), 1);
            chk("beat_clr", 32'(beat_count), 0);
         end
         if (w_valid) begin
            if (!seen_w) begin
               chk("w_lat", k, 1);
               seen_w = 1;
            end
            if (wq.size() == 0) chk("w_extra", 1, 0);
            else begin
               ew = wq.pop_front();
               chk("w_row", 32'(in_weights), 32'(ew));
            end
         end
         if (in_valid) begin
            if (!seen_in) begin
               chk("in_lat", k, 7);
               seen_in = 1;
            end
            if (mode == 1) dut_ready = (sc % 4 == 0) || (sc % 4 == 3);
            else dut_ready = 1'b1;
            sc++;
            if (dut_ready) begin
               if (pq.size() == 0) chk("pix_extra", 1, 0);
               else begin
                  ep = pq.pop_front();
                  chk("pix", 32'(in_data), 32'(ep));
               end
               acc++;
               if (acc == 64) begin
                  last_k = k;
                  if (rd_sent) exp_done_k = k + 1;
               end
            end
         end
         if (done) begin
            chk("done_lat", k, exp_done_k);
            chk("beats", 32'(beat_count), nb);
            chk("w_left", wq.size(), 0);
            chk("pix_left", pq.size(), 0);
            fin = 1;
         end
         if (!fin) begin
            if (rd_early >= 0 && acc == rd_early && in_valid && !rd_sent) begin
               res_done = 1'b1;
               rd_sent = 1;
            end
            if (rd_early < 0 && last_k >= 0 && k == last_k + 3) begin
               res_done = 1'b1;
               exp_done_k = k + 1;
            end
            if (repulse && k == 3) start = 1'b1;
            if (repulse && acc == 30 && !sp2) begin
               start = 1'b1;
               sp2 = 1;
            end
            if (beats && acc != last_b && (acc == 10 || acc == 20 || acc == 30)) begin
               res_valid = 1'b1;
               res_data = 12'h312;
               nb++;
               last_b = acc;
            end
            if (rst_at >= 0 && acc == rst_at) begin
               res_n = 1'b0;
               start = 1'b0;
               res_done = 1'b0;
               res_valid = 1'b0;
               #1;
               chk("rst_out", 32'({in_valid, w_valid, done, busy, in_data, in_weights}), 0);
               chk("rst_cnt", 32'({beat_count, pix_addr, w_addr}), 0);
               for (int i = 0; i < 3; i++) begin
                  @(posedge clk);
                  #1;
                  chk("rst_nodone", 32'({done, busy}), 0);
               end
               res_n = 1'b1;
               @(posedge clk);
               #1;
               return;
            end
         end
      end
      if (!fin) chk("timeout", 0, 1);
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(done), 0);
      chk("idle", 32'(busy), 0);
   endtask

   initial begin
      res_n = 1'b0;
      start = 1'b0;
      dut_ready = 1'b0;
      res_done = 1'b0;
      res_valid = 1'b0;
      res_data = '0;
      for (int i = 0; i < 8; i++) begin
         wmem[i] = 12'($urandom);
         if (i < 4) wmem[i][3:0] = 4'h0;
      end
      for (int i = 0; i < 64; i++) pmem[i] = 4'($urandom);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", 32'({in_valid, w_valid, done, busy, in_data, in_weights}), 0);
      chk("reset_cnt", 32'({beat_count, pix_addr, w_addr}), 0);
      res_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_after_reset", 32'({busy, w_valid, in_valid}), 0);

      run(0, -1, -1, 0, 0);
      run(1, -1, -1, 0, 0);
      run(0, 40, -1, 0, 0);
      run(0, -1, 20, 0, 0);
      run(0, -1, -1, 1, 0);
      run(0, -1, -1, 0, 1);
      run(0, -1, -1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
